// File: rtl/irq_ctrl_if.sv
// Register bus and CPU interrupt handshake for irq_ctrl.
interface irq_ctrl_if #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned VBITS = 4
);
  logic             io_rd;
  logic             io_wr;
  logic [2:0]       addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] io_dout;
  logic             irq;
  logic [VBITS-1:0] ivec;
  logic             iack;

  // CPU / bus side
  modport master (
    output io_rd, io_wr, addr, din, iack,
    input  io_dout, irq, ivec
  );

  // Interrupt controller side
  modport slave (
    input  io_rd, io_wr, addr, din, iack,
    output io_dout, irq, ivec
  );
endinterface

// File: rtl/irq_ctrl.sv
// Parametrised interrupt controller: per-channel enable, edge/level mode,
// polarity and software trigger, global enable, fixed priority (highest
// channel wins), registered register-bank read port.
module irq_ctrl #(
  parameter int unsigned WIDTH    = 18,
  parameter int unsigned CHANNELS = 15,
  parameter int unsigned VBITS    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] src,
  irq_ctrl_if.slave           bus
);

  localparam logic [2:0] AddrPend  = 3'd0;
  localparam logic [2:0] AddrEna   = 3'd1;
  localparam logic [2:0] AddrMode  = 3'd2;
  localparam logic [2:0] AddrPol   = 3'd3;
  localparam logic [2:0] AddrSwset = 3'd4;
  localparam logic [2:0] AddrCtrl  = 3'd5;

  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] ena_q;
  logic [CHANNELS-1:0] mode_q;
  logic [CHANNELS-1:0] pol_q;
  logic [CHANNELS-1:0] a_prev_q;
  logic                gie_q;
  logic [WIDTH-1:0]    dout_q;

  logic [CHANNELS-1:0] act;
  logic [CHANNELS-1:0] set_mask;
  logic [CHANNELS-1:0] clr_mask;
  logic [CHANNELS-1:0] ack_mask;
  logic [CHANNELS-1:0] cand;
  logic [VBITS-1:0]    ivec;
  logic [WIDTH-1:0]    rdata;
  logic                unused_din;

  // Only the low CHANNELS bits of din are ever stored.
  assign unused_din = ^bus.din;

  assign act = src ^ pol_q;

  // Set/clear masks for edge-mode channels; iack clears the channel it refers to.
  always_comb begin
    ack_mask = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (bus.iack && (ivec == VBITS'(i + 1))) ack_mask[i] = 1'b1;
    end
    set_mask = act & ~a_prev_q;
    if (bus.io_wr && (bus.addr == AddrSwset)) set_mask = set_mask | bus.din[CHANNELS-1:0];
    clr_mask = ack_mask;
    if (bus.io_wr && (bus.addr == AddrPend)) clr_mask = clr_mask | bus.din[CHANNELS-1:0];
    // Set wins over clear so a new event coinciding with its ack is not lost.
    pend_d = (mode_q & (set_mask | (pend_q & ~clr_mask))) | (~mode_q & act);
  end

  // Fixed priority: later (higher) channels overwrite lower ones.
  always_comb begin
    cand = gie_q ? (pend_q & ena_q) : '0;
    ivec = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cand[i]) ivec = VBITS'(i + 1);
    end
  end

  // Read mux over pre-write register values.
  always_comb begin
    rdata = '0;
    case (bus.addr)
      AddrPend: rdata[CHANNELS-1:0] = pend_q;
      AddrEna:  rdata[CHANNELS-1:0] = ena_q;
      AddrMode: rdata[CHANNELS-1:0] = mode_q;
      AddrPol:  rdata[CHANNELS-1:0] = pol_q;
      AddrCtrl: begin
        rdata[0]       = gie_q;
        rdata[VBITS:1] = ivec;
      end
      default:  rdata = '0;
    endcase
  end

  // Register state, config writes and the registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= '0;
      ena_q    <= '0;
      mode_q   <= '1;
      pol_q    <= '0;
      a_prev_q <= '0;
      gie_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      pend_q   <= pend_d;
      a_prev_q <= act;
      if (bus.io_rd) dout_q <= rdata;
      if (bus.io_wr) begin
        case (bus.addr)
          AddrEna:  ena_q  <= bus.din[CHANNELS-1:0];
          AddrMode: mode_q <= bus.din[CHANNELS-1:0];
          AddrPol:  pol_q  <= bus.din[CHANNELS-1:0];
          AddrCtrl: gie_q  <= bus.din[0];
          default:  ;
        endcase
      end
    end
  end

  assign bus.io_dout = dout_q;
  assign bus.ivec    = ivec;
  assign bus.irq     = (ivec != '0);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl.
module tb_irq_ctrl;
  localparam int unsigned W = 18;
  localparam int unsigned C = 15;
  localparam int unsigned V = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [C-1:0] src;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] rd;

  irq_ctrl_if #(.WIDTH(W), .VBITS(V)) bus ();

  irq_ctrl #(.WIDTH(W), .CHANNELS(C), .VBITS(V)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // All tasks start and end just after a falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [W-1:0] d);
    bus.io_wr = 1'b1; bus.addr = a; bus.din = d;
    step();
    bus.io_wr = 1'b0; bus.din = '0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [W-1:0] d);
    bus.io_rd = 1'b1; bus.addr = a;
    step();
    bus.io_rd = 1'b0;
    d = bus.io_dout;
  endtask

  task automatic ack();
    bus.iack = 1'b1;
    step();
    bus.iack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_cmp++;
    if (bus.irq !== 1'b0 || bus.ivec !== 4'd0 || bus.io_dout !== 18'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got irq=%0b ivec=%0d dout=%h want 0/0/0",
               bus.irq, bus.ivec, bus.io_dout);
    end
    rd_reg(3'd2, rd);
    n_cmp++;
    if (rd !== 18'h07FFF) begin n_err++; $display("FAIL reset_mode: got %h want 07fff", rd); end
    rd_reg(3'd1, rd);
    n_cmp++;
    if (rd !== 18'h0) begin n_err++; $display("FAIL reset_ena: got %h want 0", rd); end
  endtask

  task automatic test_edge();
    src[2] = 1'b1;
    step();
    n_cmp++;
    if (bus.ivec !== 4'd3 || bus.irq !== 1'b1) begin
      n_err++; $display("FAIL edge_set: got ivec=%0d irq=%0b want 3/1", bus.ivec, bus.irq);
    end
    rd_reg(3'd0, rd);
    n_cmp++;
    if (rd !== 18'h00004) begin n_err++; $display("FAIL edge_pend: got %h want 00004", rd); end
    ack();
    n_cmp++;
    if (bus.ivec !== 4'd0 || bus.irq !== 1'b0) begin
      n_err++; $display("FAIL edge_ack: got ivec=%0d irq=%0b want 0/0", bus.ivec, bus.irq);
    end
    src = '0;
    step();
  endtask

  task automatic test_priority();
    src[0] = 1'b1; src[5] = 1'b1;
    step();
    n_cmp++;
    if (bus.ivec !== 4'd6) begin n_err++; $display("FAIL prio_first: got %0d want 6", bus.ivec); end
    ack();
    n_cmp++;
    if (bus.ivec !== 4'd1) begin n_err++; $display("FAIL prio_second: got %0d want 1", bus.ivec); end
    ack();
    n_cmp++;
    if (bus.ivec !== 4'd0) begin n_err++; $display("FAIL prio_none: got %0d want 0", bus.ivec); end
    src = '0;
    step();
  endtask

  task automatic test_level();
    wr_reg(3'd2, 18'h07FEF);
    src[4] = 1'b1;
    step();
    n_cmp++;
    if (bus.ivec !== 4'd5) begin n_err++; $display("FAIL level_set: got %0d want 5", bus.ivec); end
    ack();
    step();
    n_cmp++;
    if (bus.ivec !== 4'd5) begin n_err++; $display("FAIL level_ack: got %0d want 5", bus.ivec); end
    src[4] = 1'b0;
    step();
    n_cmp++;
    if (bus.ivec !== 4'd0) begin n_err++; $display("FAIL level_drop: got %0d want 0", bus.ivec); end
    wr_reg(3'd2, 18'h07FFF);
  endtask

  task automatic test_polarity();
    // Flipping POL with src low makes channel 1 active, which is itself an edge.
    wr_reg(3'd3, 18'h00002);
    step();
    n_cmp++;
    if (bus.ivec !== 4'd2) begin n_err++; $display("FAIL pol_flip: got %0d want 2", bus.ivec); end
    wr_reg(3'd0, 18'h00002);
    src[1] = 1'b1;
    step();
    n_cmp++;
    if (bus.ivec !== 4'd0) begin n_err++; $display("FAIL pol_rise: got %0d want 0", bus.ivec); end
    src[1] = 1'b0;
    step();
    rd_reg(3'd0, rd);
    n_cmp++;
    if (rd !== 18'h00002 || bus.ivec !== 4'd2) begin
      n_err++; $display("FAIL pol_fall: got pend=%h ivec=%0d want 00002/2", rd, bus.ivec);
    end
    wr_reg(3'd0, 18'h00002);
    wr_reg(3'd3, 18'h00000);
    step();
  endtask

  task automatic test_swset();
    wr_reg(3'd4, 18'h00008);
    n_cmp++;
    if (bus.ivec !== 4'd4) begin n_err++; $display("FAIL swset: got %0d want 4", bus.ivec); end
    src[3] = 1'b1;
    wr_reg(3'd0, 18'h00008);
    rd_reg(3'd0, rd);
    n_cmp++;
    if (rd !== 18'h00008 || bus.ivec !== 4'd4) begin
      n_err++; $display("FAIL set_wins: got pend=%h ivec=%0d want 00008/4", rd, bus.ivec);
    end
    // iack and PEND write on the same bit: cleared.
    bus.iack = 1'b1;
    wr_reg(3'd0, 18'h00008);
    bus.iack = 1'b0;
    n_cmp++;
    if (bus.ivec !== 4'd0) begin n_err++; $display("FAIL ack_and_clr: got %0d want 0", bus.ivec); end
    src = '0;
    step();
  endtask

  task automatic test_back_to_back();
    src[6] = 1'b1;
    step();
    src[6] = 1'b0;
    step();
    src[6] = 1'b1;
    ack();
    n_cmp++;
    if (bus.ivec !== 4'd7) begin n_err++; $display("FAIL edge_during_ack: got %0d want 7", bus.ivec); end
    src = '0;
    ack();
    n_cmp++;
    if (bus.ivec !== 4'd0) begin n_err++; $display("FAIL b2b_clear: got %0d want 0", bus.ivec); end
    // Simultaneous read and write returns the pre-write value.
    bus.io_rd = 1'b1;
    wr_reg(3'd1, 18'h000FF);
    bus.io_rd = 1'b0;
    n_cmp++;
    if (bus.io_dout !== 18'h07FFF) begin
      n_err++; $display("FAIL rd_wr_same: got %h want 07fff", bus.io_dout);
    end
    rd_reg(3'd1, rd);
    n_cmp++;
    if (rd !== 18'h000FF) begin n_err++; $display("FAIL rd_after_wr: got %h want 000ff", rd); end
    wr_reg(3'd1, 18'h07FFF);
  endtask

  task automatic test_gie_reset();
    wr_reg(3'd4, 18'h00100);
    n_cmp++;
    if (bus.ivec !== 4'd9) begin n_err++; $display("FAIL gie_pre: got %0d want 9", bus.ivec); end
    wr_reg(3'd5, 18'h0);
    rd_reg(3'd5, rd);
    n_cmp++;
    if (bus.irq !== 1'b0 || rd !== 18'h0) begin
      n_err++; $display("FAIL gie_off: got irq=%0b ctrl=%h want 0/0", bus.irq, rd);
    end
    wr_reg(3'd5, 18'h1);
    n_cmp++;
    if (bus.irq !== 1'b1 || bus.ivec !== 4'd9) begin
      n_err++; $display("FAIL gie_on: got irq=%0b ivec=%0d want 1/9", bus.irq, bus.ivec);
    end
    rd_reg(3'd5, rd);
    n_cmp++;
    if (rd !== 18'h00013) begin n_err++; $display("FAIL ctrl_read: got %h want 00013", rd); end
    reset = 1'b1;
    src[7] = 1'b1;
    step();
    reset = 1'b0;
    src = '0;
    n_cmp++;
    if (bus.irq !== 1'b0 || bus.ivec !== 4'd0 || bus.io_dout !== 18'h0) begin
      n_err++;
      $display("FAIL mid_reset: got irq=%0b ivec=%0d dout=%h want 0/0/0",
               bus.irq, bus.ivec, bus.io_dout);
    end
    rd_reg(3'd1, rd);
    n_cmp++;
    if (rd !== 18'h0) begin n_err++; $display("FAIL reset_ena2: got %h want 0", rd); end
    rd_reg(3'd0, rd);
    n_cmp++;
    if (rd !== 18'h0) begin n_err++; $display("FAIL reset_pend2: got %h want 0", rd); end
  endtask

  initial begin
    reset = 1'b1;
    src = '0;
    bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.addr = '0; bus.din = '0; bus.iack = 1'b0;
    step();
    test_reset();
    wr_reg(3'd1, 18'h07FFF);
    wr_reg(3'd5, 18'h00001);
    test_edge();
    test_priority();
    test_level();
    test_polarity();
    test_swset();
    test_back_to_back();
    test_gie_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised interrupt controller for the chad MCU. It replaces the fixed three-source pending register and priority encoder in the MCU top level. It provides:
- N request channels, each with per-channel enable, edge/level mode, polarity and software trigger;
- a global enable;
- a CPU-readable/writable register bank on the I/O bus.

It drives the processor's `irq`/`ivec` inputs and consumes `iack`.

## Interface
Parameters:
- `WIDTH`, 18, I/O data width; must satisfy `CHANNELS <= WIDTH` and `VBITS+1 <= WIDTH`.
- `CHANNELS`, 15, number of request channels; must satisfy `CHANNELS <= 2**VBITS - 1`.
- `VBITS`, 4, interrupt vector width.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `src`  in  CHANNELS  raw request lines, already synchronous to `clk`. Bit i maps to vector i+1.
- `io_rd`  in  1  register read strobe; qualified by the I/O decode outside this block.
- `io_wr`  in  1  register write strobe.
- `addr`  in  3  register select.
- `din`  in  WIDTH  write data.
- `io_dout`  out  WIDTH  read data.
- `irq`  out  1  interrupt request to the CPU.
- `ivec`  out  VBITS  vector of the highest-priority active channel; 0 means none.
- `iack`  in  1  CPU acknowledge; refers to the `ivec` value present in the same cycle.

## Operation
Register map (addr; bits above CHANNELS read 0):
- 0 PEND: read returns pending bits. Write-1 clears pending bits of edge-mode channels.
- 1 ENA: read/write enable mask. Reset value 0.
- 2 MODE: read/write, 1 = edge, 0 = level. Reset value all 1s.
- 3 POL: read/write, 1 = active-low / falling edge. Reset value 0.
- 4 SWSET: write-1 sets pending bits of edge-mode channels. Reads 0.
- 5 CTRL: bit 0 is GIE (read/write, reset 0). Bits [VBITS:1] read the current `ivec`; writes to them are ignored.
- 6, 7: reads return 0; writes are ignored.

Per-channel logic:
- Active level: `a[i] = src[i] ^ POL[i]`.
- A registered `a_prev[i]` is kept per channel. Reset value 0.
- Edge mode: `a[i] & ~a_prev[i]` sets `pend[i]`. The bit stays set until it is cleared by `iack` (when `ivec == i+1`) or by a PEND write-1.
- Set sources for an edge-mode bit are edge detection and SWSET. If a set and a clear occur in the same cycle, set wins. If `iack` and a PEND write-1 hit the same bit, it is cleared.
- Level mode: `pend[i]` is registered `a[i]` every cycle. `iack`, PEND writes and SWSET have no effect on it.
- Changing MODE takes effect on the next cycle. A bit switched to edge mode keeps its current value.

Priority and request:
- Candidates: `c = pend & ENA`, gated by GIE.
- `ivec` = (highest set index of `c`) + 1, otherwise 0. The highest channel number has the highest priority.
- `irq = (ivec != 0)`.
- `ivec` and `irq` are combinational from registered state.

Reset: all registers go to their listed values. `io_dout`, `irq` and `ivec` are 0.

## Timing
- `src` edge/level sampled at edge n: `pend` updates at edge n, so `irq`/`ivec` are valid during cycle n+1. Source-to-irq latency is 1 clock.
- `iack` asserted in cycle n: the pend bit is clear after edge n, and `irq` drops (or `ivec` moves to the next channel) in cycle n+1.
- A new edge on the same channel in the same cycle as its `iack` leaves the bit set, so no event is lost.
- Reads: `io_dout` is registered. It is loaded at the edge where `io_rd` is high, is valid in the following cycle, and holds until the next read. Without a read it is unchanged.
- Writes take effect at the edge where `io_wr` is high.
- If `io_rd` and `io_wr` are asserted together, both are performed. Read data is the pre-write value.
- `reset` asserted mid-operation: all state is cleared at that edge, overriding every other event in the same cycle.

## Test plan
- Reset, then ENA=0x7FFF, GIE=1. Rising edge on `src[2]` at edge n → `ivec=3`, `irq=1` in cycle n+1. `iack` → `irq=0` next cycle.
- `src[0]` and `src[5]` edges in the same cycle → `ivec=6`. After `iack`, `ivec=1`. After a second `iack`, `ivec=0`.
- MODE bit 4 = 0 (level), `src[4]` held high: `iack` does not clear the request, `ivec=5` persists. Drop `src[4]` → `ivec=0` one cycle later.
- POL bit 1 = 1: falling edge on `src[1]` → PEND bit 1 set. Rising edge → no set.
- SWSET write 0x0008 → `ivec=4`. PEND write-1 0x0008 in the same cycle as a `src[3]` edge → bit remains set.
- GIE=0 with pending bits set → `irq=0` and CTRL read returns 0. Set GIE=1 → `irq` next cycle. Assert `reset` during an active `irq` → all outputs 0 and ENA/PEND read 0.
